// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit ALU: alu_ctrl decode,
// EX/MEM and MEM/WB operand forwarding, load-use stall and bubble insertion.
module id_ex_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [1:0]         id_alu_op,
  input  logic [2:0]         id_funct3,
  input  logic               id_funct7_b5,
  input  logic               id_alu_src,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               id_branch,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_alu_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_wdata,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_in1,
  output logic [XLEN-1:0]    ex_in2,
  output logic [3:0]         ex_alu_ctrl,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_branch
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [3:0]         alu_ctrl;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
  } id_ex_t;

  id_ex_t     q;
  id_ex_t     d;
  logic [3:0] alu_ctrl;
  logic       uses_rs2;
  logic       bubble;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    alu_ctrl = 4'b1111;
    unique case (1'b1)
      id_alu_op == 2'b00: alu_ctrl = 4'b0010;
      id_alu_op == 2'b01: alu_ctrl = 4'b0110;
      id_alu_op[1]: begin
        case (id_funct3)
          3'b000: alu_ctrl = (!id_alu_op[0] && id_funct7_b5)
                             ? 4'b0110 : 4'b0010;
          3'b111: alu_ctrl = 4'b0000;
          3'b110: alu_ctrl = 4'b0001;
          default: alu_ctrl = 4'b1111;
        endcase
      end
    endcase
  end

  assign uses_rs2 = !id_alu_src | id_mem_write | id_branch;

  assign hazard_stall = q.valid & q.mem_read & (q.rd != '0) & id_valid
                      & ((q.rd == id_rs1) | (uses_rs2 & (q.rd == id_rs2)));

  assign bubble = flush | hazard_stall | !id_valid;

  always_comb begin
    d            = '0;
    d.pc         = id_pc;
    d.imm        = id_imm;
    d.rs1_data   = id_rs1_data;
    d.rs2_data   = id_rs2_data;
    d.rs1        = id_rs1;
    d.rs2        = id_rs2;
    d.rd         = id_rd;
    d.alu_ctrl   = alu_ctrl;
    d.alu_src    = id_alu_src;
    if (!bubble) begin
      d.valid      = 1'b1;
      d.mem_read   = id_mem_read;
      d.mem_write  = id_mem_write;
      d.reg_write  = id_reg_write;
      d.mem_to_reg = id_mem_to_reg;
      d.branch     = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  // Youngest producer wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR_W-1:0] src,
    input logic [XLEN-1:0]    reg_data,
    input logic               em_we,
    input logic [RADDR_W-1:0] em_rd,
    input logic [XLEN-1:0]    em_val,
    input logic               mw_we,
    input logic [RADDR_W-1:0] mw_rd,
    input logic [XLEN-1:0]    mw_val
  );
    if (em_we && em_rd != '0 && em_rd == src)      return em_val;
    else if (mw_we && mw_rd != '0 && mw_rd == src) return mw_val;
    else                                           return reg_data;
  endfunction

  assign fwd_a = fwd(q.rs1, q.rs1_data, exmem_reg_write, exmem_rd,
                     exmem_alu_result, memwb_reg_write, memwb_rd,
                     memwb_wdata);
  assign fwd_b = fwd(q.rs2, q.rs2_data, exmem_reg_write, exmem_rd,
                     exmem_alu_result, memwb_reg_write, memwb_rd,
                     memwb_wdata);

  assign ex_in1        = fwd_a;
  assign ex_in2        = q.alu_src ? q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_valid      = q.valid;
  assign ex_alu_ctrl   = q.alu_ctrl;
  assign ex_pc         = q.pc;
  assign ex_imm        = q.imm;
  assign ex_rd         = q.rd;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_to_reg = q.mem_to_reg;
  assign ex_branch     = q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use stall,
// flush bubbles and reset behaviour.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_funct7_b5, id_alu_src;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic        id_mem_to_reg, id_branch;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [63:0] exmem_alu_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [63:0] memwb_wdata;
  logic        flush;
  logic        hazard_stall, ex_valid;
  logic [63:0] ex_in1, ex_in2, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_wdata(memwb_wdata), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [2:0] f3,
                        input logic b5, input logic src,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr,
                        input logic mw, input logic rw,
                        input logic br);
    id_valid      = 1'b1;
    id_alu_op     = op;
    id_funct3     = f3;
    id_funct7_b5  = b5;
    id_alu_src    = src;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_mem_read   = mr;
    id_mem_write  = mw;
    id_reg_write  = rw;
    id_mem_to_reg = mr;
    id_branch     = br;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    id_pc = 64'h100;
    id_rs1_data = 64'h1111;
    id_rs2_data = 64'h2222;
    id_imm = 64'h8;
    exmem_reg_write = 1'b0;
    exmem_rd = '0;
    exmem_alu_result = '0;
    memwb_reg_write = 1'b0;
    memwb_rd = '0;
    memwb_wdata = '0;
    set_id(2'b10, 3'b000, 1'b1, 1'b0, 5'd5, 5'd6, 5'd8, 0, 0, 1, 0);

    // Reset held three cycles with a live instruction in ID
    repeat (3) tick();
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ctrl", {60'd0, ex_alu_ctrl}, 64'd0);
    chk("rst_in1", ex_in1, 64'd0);
    chk("rst_in2", ex_in2, 64'd0);
    chk("rst_regw", {63'd0, ex_reg_write}, 64'd0);

    // R-type sub, x8 = x5 - x6
    reset = 1'b0;
    tick();
    chk("sub_valid", {63'd0, ex_valid}, 64'd1);
    chk("sub_ctrl", {60'd0, ex_alu_ctrl}, 64'h6);
    chk("sub_in1", ex_in1, 64'h1111);
    chk("sub_in2", ex_in2, 64'h2222);
    chk("sub_rd", {59'd0, ex_rd}, 64'd8);
    chk("sub_pc", ex_pc, 64'h100);

    // Forwarding priority onto rs1=5 and rs2=6
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_alu_result = 64'h10;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_wdata = 64'h20;
    settle();
    chk("fwd_exmem_wins", ex_in1, 64'h10);
    exmem_rd = 5'd0;
    settle();
    chk("fwd_exmem_x0", ex_in1, 64'h20);
    memwb_rd = 5'd0;
    settle();
    chk("fwd_none", ex_in1, 64'h1111);
    memwb_rd = 5'd6; memwb_wdata = 64'h30;
    settle();
    chk("fwd_b_in2", ex_in2, 64'h30);
    chk("fwd_b_store", ex_store_data, 64'h30);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // Load x7, then add using rs2=7
    set_id(2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd7, 1, 0, 1, 0);
    tick();
    chk("ld_ctrl", {60'd0, ex_alu_ctrl}, 64'h2);
    chk("ld_memrd", {63'd0, ex_mem_read}, 64'd1);
    chk("ld_in2_imm", ex_in2, 64'h8);
    set_id(2'b10, 3'b000, 1'b0, 1'b0, 5'd3, 5'd7, 5'd9, 0, 0, 1, 0);
    settle();
    chk("lu_stall", {63'd0, hazard_stall}, 64'd1);
    tick();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    chk("lu_bub_regw", {63'd0, ex_reg_write}, 64'd0);
    chk("lu_unstall", {63'd0, hazard_stall}, 64'd0);
    tick();
    chk("lu_reissue", {63'd0, ex_valid}, 64'd1);
    chk("lu_reissue_rd", {59'd0, ex_rd}, 64'd9);

    // I-type with stray rs2 field matching a load rd: no stall
    set_id(2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd7, 1, 0, 1, 0);
    tick();
    set_id(2'b11, 3'b000, 1'b0, 1'b1, 5'd1, 5'd7, 5'd4, 0, 0, 1, 0);
    settle();
    chk("itype_nostall", {63'd0, hazard_stall}, 64'd0);

    // Flushed store
    set_id(2'b00, 3'b011, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 0, 1, 0, 0);
    flush = 1'b1;
    tick();
    chk("fl_memw", {63'd0, ex_mem_write}, 64'd0);
    chk("fl_valid", {63'd0, ex_valid}, 64'd0);

    // Flush and stall together give a single bubble
    flush = 1'b0;
    set_id(2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd7, 1, 0, 1, 0);
    tick();
    set_id(2'b10, 3'b111, 1'b0, 1'b0, 5'd7, 5'd1, 5'd10, 0, 0, 1, 0);
    flush = 1'b1;
    settle();
    chk("fs_stall", {63'd0, hazard_stall}, 64'd1);
    tick();
    chk("fs_bubble", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;
    settle();
    chk("fs_nostall", {63'd0, hazard_stall}, 64'd0);
    tick();
    chk("fs_and_valid", {63'd0, ex_valid}, 64'd1);
    chk("fs_and_ctrl", {60'd0, ex_alu_ctrl}, 64'h0);

    // I-type addi with b5=1 and negative immediate
    set_id(2'b11, 3'b000, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    id_imm = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("addi_ctrl", {60'd0, ex_alu_ctrl}, 64'h2);
    chk("addi_in2", ex_in2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // Remaining decode rows
    set_id(2'b11, 3'b110, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    tick();
    chk("ori_ctrl", {60'd0, ex_alu_ctrl}, 64'h1);
    set_id(2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    tick();
    chk("slt_ctrl", {60'd0, ex_alu_ctrl}, 64'hF);
    set_id(2'b01, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1);
    tick();
    chk("br_ctrl", {60'd0, ex_alu_ctrl}, 64'h6);
    chk("br_branch", {63'd0, ex_branch}, 64'd1);

    // Empty decode slot
    id_valid = 1'b0;
    tick();
    chk("inv_valid", {63'd0, ex_valid}, 64'd0);
    chk("inv_branch", {63'd0, ex_branch}, 64'd0);

    // Reset during a load-use stall
    set_id(2'b00, 3'b011, 1'b0, 1'b1, 5'd2, 5'd0, 5'd7, 1, 0, 1, 0);
    tick();
    set_id(2'b10, 3'b000, 1'b0, 1'b0, 5'd7, 5'd1, 5'd9, 0, 0, 1, 0);
    settle();
    chk("rs_stall", {63'd0, hazard_stall}, 64'd1);
    reset = 1'b1;
    tick();
    chk("rs_valid", {63'd0, ex_valid}, 64'd0);
    chk("rs_nostall", {63'd0, hazard_stall}, 64'd0);
    chk("rs_memrd", {63'd0, ex_mem_read}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
